// File: rtl/serial_add_ctrl_pkg.sv
// Shared FSM encodings for the bit-serial adder sequencer.
package serial_add_ctrl_pkg;

  // Code 2'd3 is unused and decodes back to StIdle.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder; two of these plus an OR make the serial full adder.
module half_adder (
  input  logic A,
  input  logic B,
  output logic S,
  output logic C
);

  assign S = A ^ B;
  assign C = A & B;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per clock through a shared
// full adder, with a start/busy/done handshake and a held result register.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  import serial_add_ctrl_pkg::*;

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic            w_load;
  logic            w_step;
  logic            w_last;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic             r_carry;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic w_s1;
  logic w_c1;
  logic w_s;
  logic w_c2;
  logic w_c;

  // Full adder built from two half adders sharing the registered carry.
  half_adder u_ha0 (
    .A (r_a_sr[0]),
    .B (r_b_sr[0]),
    .S (w_s1),
    .C (w_c1)
  );

  half_adder u_ha1 (
    .A (w_s1),
    .B (r_carry),
    .S (w_s),
    .C (w_c2)
  );

  assign w_c       = w_c1 | w_c2;
  // Sum bits enter at the MSB so after WIDTH steps bit 0 sits at the LSB.
  assign w_acc_nxt = {w_s, r_acc[WIDTH-1:1]};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      StIdle: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = StRun;
        end
      end
      StRun: begin
        w_step = 1'b1;
        if (r_cnt == CntLast) begin
          w_last      = 1'b1;
          w_state_nxt = StDone;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Operand shift registers, carry flop, accumulator and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_a_sr  <= a;
      r_b_sr  <= b;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_acc   <= w_acc_nxt;
      r_carry <= w_c;
      r_cnt   <= r_cnt + CntW'(1);
    end
  end

  // Result registers update only on the final RUN step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_last) begin
      r_sum  <= w_acc_nxt;
      r_cout <= w_c;
    end
  end

  assign busy = (r_state == StRun);
  assign done = (r_state == StDone);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=4.
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] sum8;
  logic       cout8;
  logic       start4;
  logic [3:0] a4;
  logic [3:0] b4;
  logic       busy4;
  logic       done4;
  logic [3:0] sum4;
  logic       cout4;

  int checks;
  int failures;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one 8-bit op from IDLE; returns edges from capture to done and busy cycle count.
  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      output int lat, output int bcnt);
    @(negedge clk);
    a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = -1;
    bcnt = 0;
    for (int k = 0; k <= 20; k++) begin
      if (done8) begin
        lat = k;
        break;
      end
      if (busy8) bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start8 = 1'b0; start4 = 1'b0;
    a8 = '0; b8 = '0; a4 = '0; b4 = '0;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8} !== 11'h0) begin
      failures++;
      $display("FAIL reset8_pre_clk: got %h expected 000", {busy8, done8, sum8, cout8});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy8, done8, sum8, cout8} !== 11'h0) begin
      failures++;
      $display("FAIL reset8_clocked: got %h expected 000", {busy8, done8, sum8, cout8});
    end
    checks++;
    if ({busy4, done4, sum4, cout4} !== 7'h0) begin
      failures++;
      $display("FAIL reset4: got %h expected 00", {busy4, done4, sum4, cout4});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    int bcnt;
    run8(8'h05, 8'h03, lat, bcnt);
    checks++;
    if (lat != 8) begin
      failures++;
      $display("FAIL basic_latency: got %0d expected 8", lat);
    end
    checks++;
    if (bcnt != 8) begin
      failures++;
      $display("FAIL basic_busy_cycles: got %0d expected 8", bcnt);
    end
    checks++;
    if ({cout8, sum8} !== 9'h008) begin
      failures++;
      $display("FAIL basic_result: got %h expected 008", {cout8, sum8});
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b expected 0 0", done8, busy8);
    end
    checks++;
    if (sum8 !== 8'h08) begin
      failures++;
      $display("FAIL basic_hold: got %h expected 08", sum8);
    end
  endtask

  task automatic test_ripple();
    int lat;
    int bcnt;
    run8(8'hFF, 8'h01, lat, bcnt);
    checks++;
    if (lat != 8) begin
      failures++;
      $display("FAIL ripple_latency: got %0d expected 8", lat);
    end
    checks++;
    if ({cout8, sum8} !== 9'h100) begin
      failures++;
      $display("FAIL ripple_result: got %h expected 100", {cout8, sum8});
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    int  lat;
    int  lat2;
    logic held;
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'hF0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Mid-run request with new operands; must not disturb the first op.
    a8 = 8'h11; b8 = 8'h11; start8 = 1'b1;
    lat = -1;
    for (int k = 2; k <= 20; k++) begin
      if (done8) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat != 8) begin
      failures++;
      $display("FAIL ignore_latency: got %0d expected 8", lat);
    end
    checks++;
    if ({cout8, sum8} !== 9'h0FF) begin
      failures++;
      $display("FAIL ignore_first_result: got %h expected 0ff", {cout8, sum8});
    end
    lat2 = -1;
    held = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done8) begin
        lat2 = k;
        break;
      end
      if (sum8 !== 8'hFF) held = 1'b0;
    end
    start8 = 1'b0;
    checks++;
    if (lat2 != 10) begin
      failures++;
      $display("FAIL back_to_back_period: got %0d expected 10", lat2);
    end
    checks++;
    if (held !== 1'b1) begin
      failures++;
      $display("FAIL hold_during_run: got %b expected 1", held);
    end
    checks++;
    if ({cout8, sum8} !== 9'h022) begin
      failures++;
      $display("FAIL ignore_second_result: got %h expected 022", {cout8, sum8});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int   lat;
    int   bcnt;
    logic saw_done;
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, sum8, cout8} !== 11'h0) begin
      failures++;
      $display("FAIL abort_outputs: got %h expected 000", {busy8, done8, sum8, cout8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done8 || busy8) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_done: got %b expected 0", saw_done);
    end
    run8(8'hAA, 8'h55, lat, bcnt);
    checks++;
    if (lat != 8 || {cout8, sum8} !== 9'h0FF) begin
      failures++;
      $display("FAIL abort_rerun: got lat=%0d res=%h expected lat=8 res=0ff", lat, {cout8, sum8});
    end
    @(negedge clk);
  endtask

  task automatic test_width4_sweep();
    logic [3:0] prev_sum;
    logic [3:0] ea;
    logic [3:0] eb;
    logic [7:0] nxt;
    logic [4:0] exp_res;
    logic       got;
    logic       stable;
    prev_sum = 4'h0;
    @(negedge clk);
    a4 = 4'h0; b4 = 4'h0; start4 = 1'b1;
    for (int idx = 0; idx < 256; idx++) begin
      ea = a4;
      eb = b4;
      exp_res = {1'b0, ea} + {1'b0, eb};
      got = 1'b0;
      stable = 1'b1;
      for (int k = 0; k <= 12; k++) begin
        @(negedge clk);
        if (done4) begin
          got = 1'b1;
          break;
        end
        if (sum4 !== prev_sum) stable = 1'b0;
      end
      checks++;
      if (!got) begin
        failures++;
        $display("FAIL w4_timeout: pair %0d got no done expected done", idx);
        break;
      end else if ({cout4, sum4} !== exp_res) begin
        failures++;
        $display("FAIL w4_result: %h+%h got %h expected %h", ea, eb, {cout4, sum4}, exp_res);
      end
      checks++;
      if (stable !== 1'b1) begin
        failures++;
        $display("FAIL w4_sum_stable: pair %0d got unstable expected held %h", idx, prev_sum);
      end
      prev_sum = exp_res[3:0];
      nxt = 8'(idx + 1);
      a4 = nxt[7:4];
      b4 = nxt[3:0];
    end
    start4 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_ripple();
    test_start_ignored();
    test_reset_abort();
    test_width4_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
